// File: rtl/llssine_deadlock_report_unit_pkg.sv
// Shared types, defaults and helpers for the deadlock report path.
package llssine_dl_pkg;

    // Report FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ORIGIN = 2'd1,
        ST_TRACE  = 2'd2,
        ST_REPORT = 2'd3
    } dl_state_e;

    // Default bound on the token walk before the trace is force-closed
    localparam int DL_TRACE_TMO_DEF = 64;

    // Widest process vector the onehot helper can build
    localparam int DL_MAX_PROC = 32;

    // One-hot strobe for a process index; callers size-cast to their vector width
    function automatic logic [DL_MAX_PROC-1:0] onehot(input logic [4:0] id);
        logic [DL_MAX_PROC-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/llssine_deadlock_report_unit_if.sv
// Bundle between the detect units / status register and the report unit.
interface llssine_deadlock_report_unit_if #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2
);
    logic [PROC_NUM-1:0] dl_detect_vec;
    logic [PROC_NUM-1:0] proc_token_vec;
    logic                report_ack;
    logic [PROC_NUM-1:0] origin_vec;
    logic                token_clear;
    logic                dl_detected;
    logic [ID_W-1:0]     dl_origin_id;
    logic [PROC_NUM-1:0] dl_proc_mask;
    logic                dl_trace_tmo;

    // Detect units and software side
    modport master (
        output dl_detect_vec, proc_token_vec, report_ack,
        input  origin_vec, token_clear, dl_detected, dl_origin_id, dl_proc_mask, dl_trace_tmo
    );

    // Report unit side
    modport slave (
        input  dl_detect_vec, proc_token_vec, report_ack,
        output origin_vec, token_clear, dl_detected, dl_origin_id, dl_proc_mask, dl_trace_tmo
    );
endinterface

// File: rtl/llssine_deadlock_report_unit_prio_enc.sv
// Lowest-set-bit encoder: picks the lowest-numbered requesting process.
module llssine_dl_prio_enc #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2
) (
    input  logic [PROC_NUM-1:0] req,
    output logic                valid,
    output logic [ID_W-1:0]     idx
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/llssine_deadlock_report_unit.sv
// Deadlock report unit: arbitrates one origin, traces the token walk around the
// dependency cycle, clears tokens and holds a sticky report until acknowledged.
module llssine_deadlock_report_unit
    import llssine_dl_pkg::*;
#(
    parameter int PROC_NUM  = 4,
    parameter int ID_W      = 2,
    parameter int TRACE_TMO = DL_TRACE_TMO_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    llssine_deadlock_report_unit_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ORIGIN = ST_ORIGIN;
    localparam logic [1:0] S_TRACE  = ST_TRACE;
    localparam logic [1:0] S_REPORT = ST_REPORT;

    localparam int              TMR_W    = $clog2(TRACE_TMO);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TRACE_TMO - 1);

    logic [1:0]          state_q, state_d;
    logic [ID_W-1:0]     origin_id_q, origin_id_d;
    logic [PROC_NUM-1:0] mask_q, mask_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                detected_q, detected_d;
    logic                trace_tmo_q, trace_tmo_d;

    logic                arb_valid;
    logic [ID_W-1:0]     arb_idx;
    logic [PROC_NUM-1:0] origin_oh;
    logic                close;
    logic                tmo;
    logic [PROC_NUM-1:0] origin_vec_c;
    logic                token_clear_c;

    llssine_dl_prio_enc #(
        .PROC_NUM (PROC_NUM),
        .ID_W     (ID_W)
    ) u_prio_enc (
        .req   (bus.dl_detect_vec),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign origin_oh = PROC_NUM'(onehot(5'(origin_id_q)));

    // The token is back home when the origin both holds it and still flags deadlock
    assign close = bus.dl_detect_vec[origin_id_q] & bus.proc_token_vec[origin_id_q];
    assign tmo   = (timer_q == TMO_LAST);

    // Next-state, report registers and the combinational strobes
    always_comb begin
        state_d       = state_q;
        origin_id_d   = origin_id_q;
        mask_d        = mask_q;
        timer_d       = timer_q;
        detected_d    = detected_q;
        trace_tmo_d   = trace_tmo_q;
        origin_vec_c  = '0;
        token_clear_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    origin_id_d = arb_idx;
                    state_d     = S_ORIGIN;
                end
            end
            S_ORIGIN: begin
                origin_vec_c = origin_oh;
                mask_d       = origin_oh;
                timer_d      = '0;
                state_d      = S_TRACE;
            end
            S_TRACE: begin
                mask_d = mask_q | bus.proc_token_vec;
                if (close || tmo) begin
                    // Clear in the same cycle the walk ends; close wins over timeout
                    token_clear_c = 1'b1;
                    detected_d    = 1'b1;
                    trace_tmo_d   = tmo & ~close;
                    timer_d       = '0;
                    state_d       = S_REPORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_REPORT: begin
                // New detections are ignored until software consumes the report
                if (bus.report_ack) begin
                    detected_d  = 1'b0;
                    trace_tmo_d = 1'b0;
                    origin_id_d = '0;
                    mask_d      = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and report registers; reset overrides everything on its edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            origin_id_q <= '0;
            mask_q      <= '0;
            timer_q     <= '0;
            detected_q  <= 1'b0;
            trace_tmo_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            origin_id_q <= origin_id_d;
            mask_q      <= mask_d;
            timer_q     <= timer_d;
            detected_q  <= detected_d;
            trace_tmo_q <= trace_tmo_d;
        end
    end

    assign bus.origin_vec   = origin_vec_c;
    assign bus.token_clear  = token_clear_c;
    assign bus.dl_detected  = detected_q;
    assign bus.dl_origin_id = origin_id_q;
    assign bus.dl_proc_mask = mask_q;
    assign bus.dl_trace_tmo = trace_tmo_q;

endmodule
